// File: rtl/branch_sequencer.sv
// branch_sequencer: multicycle control for beq/bne/bgt/ble through the shared ALU and branch-resolve unit.
module branch_sequencer #(
  parameter logic [5:0] OP_BEQ = 6'h04,
  parameter logic [5:0] OP_BNE = 6'h05,
  parameter logic [5:0] OP_BLE = 6'h06,
  parameter logic [5:0] OP_BGT = 6'h07
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic       gt,
  input  logic       lt,
  input  logic       et,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       alu_out_write,
  output logic [1:0] branch_op,
  output logic       pc_write,
  output logic       taken
);
  typedef enum logic [1:0] {IDLE, TARGET, COMPARE, DONE} state_e;
  state_e     state_q, state_d;
  logic [1:0] op_q, op_d, op_map;
  logic       taken_q, taken_d, legal, cond;
  logic       in_i, in_t, in_c, in_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      taken_q <= taken_d;
    end
  end
  always_comb begin
    legal   = opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_BLE || opcode == OP_BGT;
    op_map  = opcode == OP_BNE ? 2'b01 : opcode == OP_BGT ? 2'b10 : opcode == OP_BLE ? 2'b11 : 2'b00;
    cond    = op_q == 2'b00 ? et : op_q == 2'b01 ? ~et : op_q == 2'b10 ? gt : (lt | et);
    state_d = state_q == IDLE    ? ((start && legal) ? TARGET : IDLE) :
              state_q == TARGET  ? COMPARE :
              state_q == COMPARE ? DONE : IDLE;
    op_d    = (state_q == IDLE && start && legal) ? op_map : op_q;
    taken_d = state_q == COMPARE ? cond : taken_q;
  end
  // Reset masks every output so nothing (notably pc_write) escapes on the reset cycle.
  always_comb begin
    in_i          = ~reset && state_q == IDLE;
    in_t          = ~reset && state_q == TARGET;
    in_c          = ~reset && state_q == COMPARE;
    in_d          = ~reset && state_q == DONE;
    busy          = in_t | in_c | in_d;
    done          = in_d;
    illegal       = in_i & start & ~legal;
    alu_src_a     = in_c;
    alu_src_b     = in_t ? 2'b10 : 2'b00;
    alu_ctrl      = in_t ? 3'b001 : in_c ? 3'b010 : 3'b000;
    alu_out_write = in_t;
    branch_op     = in_c ? op_q : 2'b00;
    pc_write      = in_c & cond;
    taken         = in_c ? cond : in_d & taken_q;
  end
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: per-scenario checks of branch_sequencer against a cycle-count reference model.
module tb_branch_sequencer;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, gt = 1'b0, lt = 1'b0, et = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       busy, done, illegal, alu_src_a, alu_out_write, pc_write, taken;
  logic [1:0] alu_src_b, branch_op;
  logic [2:0] alu_ctrl;
  logic [13:0] obs;
  int checks = 0, errors = 0;
  int k = 0;
  logic [5:0] mop = 6'h00;
  logic tq = 1'b0;

  branch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .gt(gt), .lt(lt), .et(et),
    .busy(busy), .done(done), .illegal(illegal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .alu_out_write(alu_out_write), .branch_op(branch_op),
    .pc_write(pc_write), .taken(taken)
  );

  always #5 clk = ~clk;
  assign obs = {busy, done, illegal, alu_src_a, alu_src_b, alu_ctrl, alu_out_write, branch_op, pc_write, taken};

  // k = cycles since acceptance (0 = idle); mop is the full accepted opcode.
  function automatic logic is_legal(input logic [5:0] o);
    return o >= 6'h04 && o <= 6'h07;
  endfunction
  function automatic logic mcond(input logic [5:0] o, input logic g, input logic l, input logic e);
    case (o)
      6'h04:   return e;
      6'h05:   return !e;
      6'h07:   return g;
      default: return l || e;
    endcase
  endfunction
  function automatic logic [1:0] mbop(input logic [5:0] o);
    case (o)
      6'h04:   return 2'd0;
      6'h05:   return 2'd1;
      6'h07:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction
  function automatic logic [13:0] expv();
    logic c;
    if (reset) return 14'd0;
    c = mcond(mop, gt, lt, et);
    case (k)
      0:       return {2'b00, start && !is_legal(opcode), 11'd0};
      1:       return {1'b1, 3'b000, 2'b10, 3'b001, 1'b1, 2'b00, 2'b00};
      2:       return {1'b1, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, mbop(mop), c, c};
      default: return {2'b11, 11'd0, tq};
    endcase
  endfunction
  task automatic mstep();
    if (reset) begin
      k = 0; mop = 6'h00; tq = 1'b0;
    end else case (k)
      0: if (start && is_legal(opcode)) begin k = 1; mop = opcode; end
      1: k = 2;
      2: begin tq = mcond(mop, gt, lt, et); k = 3; end
      default: k = 0;
    endcase
  endtask
  task automatic drive(input logic s, input logic [5:0] o, input logic [2:0] f, input logic r);
    @(negedge clk);
    start = s; opcode = o; {gt, lt, et} = f; reset = r;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 6'h00, 3'b000, i < 2);
      checks++;
      if (obs !== expv() || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, expv());
      end
      mstep();
    end
  endtask

  task automatic test_beq_taken();
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, 6'h04, 3'b001, 1'b0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL beq_taken cyc=%0d got=%b exp=%b", i, obs, expv());
      end
      if (i == 2) begin
        checks++;
        if ({alu_ctrl, branch_op, pc_write, taken} !== 7'b010_00_1_1) begin
          errors++;
          $display("FAIL beq_compare got=%b exp=%b", {alu_ctrl, branch_op, pc_write, taken}, 7'b0100011);
        end
      end
      if (i == 3) begin
        checks++;
        if ({done, taken} !== 2'b11) begin
          errors++;
          $display("FAIL beq_done got=%b exp=11", {done, taken});
        end
      end
      mstep();
    end
  endtask

  task automatic test_bne_not_taken();
    int pcw = 0, dn = 0;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, 6'h05, 3'b001, 1'b0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL bne_cycle cyc=%0d got=%b exp=%b", i, obs, expv());
      end
      pcw += pc_write;
      dn += done;
      if (done && taken !== 1'b0) begin
        errors++;
        $display("FAIL bne_taken got=%b exp=0", taken);
      end
      mstep();
    end
    checks++;
    if (pcw != 0 || dn != 1) begin
      errors++;
      $display("FAIL bne_counts pc_write=%0d done=%0d exp 0 and 1", pcw, dn);
    end
  endtask

  task automatic test_ble_bgt();
    logic [5:0] ops [3] = '{6'h06, 6'h06, 6'h07};
    logic [2:0] fl  [3] = '{3'b001, 3'b100, 3'b100};
    logic       pw  [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0] bo  [3] = '{2'b11, 2'b11, 2'b10};
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 4; i++) begin
        drive(i == 0, ops[t], fl[t], 1'b0);
        checks++;
        if (obs !== expv()) begin
          errors++;
          $display("FAIL ble_bgt run=%0d cyc=%0d got=%b exp=%b", t, i, obs, expv());
        end
        if (i == 2) begin
          checks++;
          if ({pc_write, branch_op} !== {pw[t], bo[t]}) begin
            errors++;
            $display("FAIL ble_bgt_resolve run=%0d got=%b exp=%b", t, {pc_write, branch_op}, {pw[t], bo[t]});
          end
        end
        mstep();
      end
  endtask

  task automatic test_illegal_busy();
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, 6'h08, 3'b000, 1'b0);
      checks++;
      if (illegal !== (i == 0) || busy !== 1'b0 || obs !== expv()) begin
        errors++;
        $display("FAIL illegal cyc=%0d illegal=%b busy=%b exp illegal=%0d busy=0", i, illegal, busy, i == 0);
      end
      mstep();
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive(1'b1, 6'h05, 3'b001, 1'b0);
      else drive(i == 0, 6'h04, 3'b001, 1'b0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL busy_start cyc=%0d got=%b exp=%b", i, obs, expv());
      end
      if (i == 2) begin
        checks++;
        if ({branch_op, pc_write} !== 3'b001) begin
          errors++;
          $display("FAIL busy_start_op got=%b exp=001", {branch_op, pc_write});
        end
      end
      mstep();
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    for (int i = 0; i < 7; i++) begin
      drive(i == 0, 6'h04, 3'b001, i == 2);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, obs, expv());
      end
      if (i == 2 && pc_write !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_pcw got=%b exp=0", pc_write);
      end
      if (i == 3 && busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle busy=%b exp=0", busy);
      end
      dn += done;
      mstep();
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL reset_mid_done count=%0d exp=0", dn);
    end
  endtask

  task automatic test_random();
    logic [5:0] o;
    for (int i = 0; i < 400; i++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(4, 7));
      drive($urandom_range(0, 1) == 1, o, 3'($urandom), $urandom_range(0, 49) == 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random cyc=%0d k=%0d got=%b exp=%b", i, k, obs, expv());
      end
      mstep();
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_ble_bgt();
    test_illegal_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multicycle controller that sequences one conditional-branch instruction (beq, bne, bgt, ble) through the shared ALU and the branch-resolve unit.
- Invoked by the main control unit after decode. Owns the ALU mux selects, ALU control, ALUOut write, branch-op select and the PC write strobe until it reports done.
- The main control unit must not drive these resources while busy=1.

Parameters:
- OP_BEQ, 6'h04, opcode treated as beq
- OP_BNE, 6'h05, opcode treated as bne
- OP_BLE, 6'h06, opcode treated as ble
- OP_BGT, 6'h07, opcode treated as bgt

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to execute a branch; sampled only in IDLE
- opcode  in  6  instruction opcode; captured when start is accepted
- gt  in  1  ALU flag, rs > rt (signed); valid during COMPARE
- lt  in  1  ALU flag, rs < rt (signed); valid during COMPARE
- et  in  1  ALU flag, rs == rt; valid during COMPARE
- busy  out  1  high in TARGET, COMPARE and DONE
- done  out  1  one-cycle pulse in DONE
- illegal  out  1  one-cycle pulse when start arrives with an unsupported opcode
- alu_src_a  out  1  0 = PC (already PC+4), 1 = register A (rs)
- alu_src_b  out  2  00 = register B (rt), 01 = constant 4, 10 = sign-extended imm<<2, 11 unused
- alu_ctrl  out  3  001 = add, 010 = sub, 000 = idle
- alu_out_write  out  1  load ALUOut register (branch target)
- branch_op  out  2  00 beq, 01 bne, 10 bgt, 11 ble; feeds the branch-resolve mux
- pc_write  out  1  PC load strobe; PC takes the branch target
- taken  out  1  resolved branch outcome; held from COMPARE through DONE

Behaviour:
- Reset: state=IDLE and opcode/op registers cleared. All outputs are 0, including alu_ctrl=000 and branch_op=00. Reset takes effect in any state, including mid-sequence; no pc_write is issued on the reset cycle.
- States: IDLE, TARGET, COMPARE, DONE. Outputs are Moore-decoded from state, except pc_write and taken in COMPARE, which are combinational from the flags.
- IDLE:
  - All outputs 0.
  - start=1 with a legal opcode: latch opcode as a 2-bit op, go to TARGET.
  - start=1 with an illegal opcode: illegal=1 for that same cycle, stay in IDLE.
  - start=0: stay in IDLE.
- TARGET:
  - Outputs: alu_src_a=0, alu_src_b=10, alu_ctrl=001, alu_out_write=1, busy=1.
  - ALUOut <= (PC+4) + (sext(imm)<<2).
  - Always go to COMPARE.
- COMPARE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_ctrl=010, alu_out_write=0, branch_op=latched op, busy=1.
  - cond: beq=et; bne=~et; bgt=gt; ble=lt|et.
  - pc_write=cond, and taken=cond in the same cycle.
  - taken_q <= cond. Go to DONE.
- DONE:
  - Outputs: done=1, busy=1, taken=taken_q. All ALU controls 0, pc_write=0.
  - Go to IDLE.
- Latency: the start-accept cycle is IDLE; done is asserted in the 3rd cycle after acceptance. No back-to-back acceptance: the next start can be accepted at the earliest in the cycle after DONE.
- start while busy is ignored and has no side effects. opcode changes after acceptance have no effect.
- pc_write is asserted at most once per sequence and only in COMPARE. It is never asserted when cond=0.
- Flag inputs are ignored outside COMPARE, including conflicting combinations such as gt=lt=1.
- Outside IDLE, taken remains 0 until COMPARE.

Test Plan:
- Reset then idle: hold reset 2 cycles, start=0 -> all outputs 0, busy=0 for 5 cycles.
- beq taken: start with opcode=6'h04; in COMPARE drive et=1 -> TARGET shows alu_src_b=10, alu_ctrl=001, alu_out_write=1; COMPARE shows alu_ctrl=010, branch_op=00, pc_write=1, taken=1; done pulses 3 cycles after accept with taken=1.
- bne not taken: opcode=6'h05, et=1 in COMPARE -> pc_write=0 in every cycle, taken=0 in DONE, done pulses once.
- ble boundary: opcode=6'h06 with {gt,lt,et}=001 -> pc_write=1. Rerun with 100 -> pc_write=0. bgt with 100 -> pc_write=1 and branch_op=10.
- Illegal and busy start: opcode=6'h08 -> illegal=1 for 1 cycle, busy stays 0. During a beq sequence, pulse start with opcode=6'h05 in TARGET -> ignored, branch_op stays 00.
- Reset mid-op: assert reset in COMPARE with et=1 on a beq -> pc_write=0 in that cycle, next cycle state=IDLE, done never pulses.
